// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the per-pixel flag bundle carried down the read pipeline.
// Macro VGA_FRAME_BORDER_EN adds a border flag to the bundle.
package vga_timing_pkg;

    localparam int H_BITS = 10;
    localparam int V_BITS = 10;

    typedef logic [H_BITS-1:0] h_cnt_t;
    typedef logic [V_BITS-1:0] v_cnt_t;

    localparam h_cnt_t H_ACTIVE = 10'd640;
    localparam h_cnt_t H_FP     = 10'd16;
    localparam h_cnt_t H_SYNC   = 10'd96;
    localparam h_cnt_t H_BP     = 10'd48;
    localparam h_cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam v_cnt_t V_ACTIVE = 10'd480;
    localparam v_cnt_t V_FP     = 10'd10;
    localparam v_cnt_t V_SYNC   = 10'd2;
    localparam v_cnt_t V_BP     = 10'd33;
    localparam v_cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam h_cnt_t H_LAST       = H_TOTAL - h_cnt_t'(1);
    localparam v_cnt_t V_LAST       = V_TOTAL - v_cnt_t'(1);
    localparam h_cnt_t H_SYNC_START = H_ACTIVE + H_FP;
    localparam h_cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam v_cnt_t V_SYNC_START = V_ACTIVE + V_FP;
    localparam v_cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Counter value to pins: counter stage, address register, output register.
    localparam int PIPE_LATENCY = 3;
    localparam int RGB_WIDTH    = 3;

    // Sync flags are active-high here; inversion to the active-low pins happens at the output.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
`ifdef VGA_FRAME_BORDER_EN
        logic border;
`endif
    } pix_flags_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Raster counters for 640x480@60 plus raw active/sync flags and the frame-start pulse.
module vga_sync_counter
    import vga_timing_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    output logic [H_BITS-1:0] o_h,
    output logic [V_BITS-1:0] o_v,
    output logic              o_active,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_frame_start
);

    h_cnt_t r_h;
    v_cnt_t r_v;

    // NOTE: sequential state uses non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + v_cnt_t'(1);
        end else begin
            r_h <= r_h + h_cnt_t'(1);
        end
    end

    assign o_h      = r_h;
    assign o_v      = r_v;
    assign o_active = (r_h < H_ACTIVE) && (r_v < V_ACTIVE);
    assign o_hsync  = (r_h >= H_SYNC_START) && (r_h < H_SYNC_END);
    assign o_vsync  = (r_v >= V_SYNC_START) && (r_v < V_SYNC_END);

    // Counters sit at (0,0) throughout reset; the pulse waits for the first running clock.
    assign o_frame_start = ~Reset && (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// Read side of the video RAM: scans cells in raster order and drives VGA sync and 3-bit RGB.
// Optional macro VGA_FRAME_BORDER_EN forces a white one-pixel frame around the active area.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int CELL_SHIFT = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [DATA_WIDTH-1:0] iRamData,
    output logic                  oVGA_R,
    output logic                  oVGA_G,
    output logic                  oVGA_B,
    output logic                  oHSync,
    output logic                  oVSync,
    output logic                  oFrameStart
);

    localparam int COLS    = int'(H_ACTIVE) >> CELL_SHIFT;
    localparam int OUT_TAP = PIPE_LATENCY - 2;

    logic [H_BITS-1:0]     w_h;
    logic [V_BITS-1:0]     w_v;
    logic                  w_active;
    logic                  w_hsync;
    logic                  w_vsync;
    pix_flags_t            w_flags;
    logic [ADDR_WIDTH-1:0] w_row;
    logic [ADDR_WIDTH-1:0] w_col;
    logic [ADDR_WIDTH-1:0] w_row_base;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [RGB_WIDTH-1:0]  w_rgb;
    logic                  w_unused_data;

    logic [ADDR_WIDTH-1:0] r_addr;
    pix_flags_t            r_flags [PIPE_LATENCY-1];
    logic [RGB_WIDTH-1:0]  r_rgb;
    logic                  r_hsync_n;
    logic                  r_vsync_n;

    vga_sync_counter u_sync (
        .Clock         (Clock),
        .Reset         (Reset),
        .o_h           (w_h),
        .o_v           (w_v),
        .o_active      (w_active),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_frame_start (oFrameStart)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_flags        = '0;
        w_flags.active = w_active;
        w_flags.hsync  = w_hsync;
        w_flags.vsync  = w_vsync;
`ifdef VGA_FRAME_BORDER_EN
        w_flags.border = (w_h == '0) || (w_h == h_cnt_t'(H_ACTIVE - 1))
                      || (w_v == '0) || (w_v == v_cnt_t'(V_ACTIVE - 1));
`endif
    end

    assign w_row = ADDR_WIDTH'(w_v >> CELL_SHIFT);
    assign w_col = ADDR_WIDTH'(w_h >> CELL_SHIFT);

    // Row times the constant column count, as a sum of shifted rows (80 = 64 + 16).
    always_comb begin
        w_row_base = '0;
        for (int i = 0; i < 32; i++) begin
            if (COLS[i]) begin
                w_row_base = w_row_base + (w_row << i);
            end
        end
    end

    assign w_addr = w_row_base + w_col;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_addr <= '0;
            // NOTE: a two-entry flag pipeline, not a RAM, so every entry is cleared on reset.
            for (int i = 0; i < PIPE_LATENCY - 1; i++) begin
                r_flags[i] <= '0;
            end
        end else begin
            r_addr     <= w_flags.active ? w_addr : '0;
            r_flags[0] <= w_flags;
            for (int i = 1; i < PIPE_LATENCY - 1; i++) begin
                r_flags[i] <= r_flags[i-1];
            end
        end
    end

    always_comb begin
        w_rgb = '0;
        if (r_flags[OUT_TAP].active) begin
            w_rgb = iRamData[RGB_WIDTH-1:0];
`ifdef VGA_FRAME_BORDER_EN
            if (r_flags[OUT_TAP].border) begin
                w_rgb = '1;
            end
`endif
        end
    end

    // Sync is registered from the same flag tap as RGB so the picture stays aligned to sync.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rgb     <= '0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
        end else begin
            r_rgb     <= w_rgb;
            r_hsync_n <= ~r_flags[OUT_TAP].hsync;
            r_vsync_n <= ~r_flags[OUT_TAP].vsync;
        end
    end

    assign w_unused_data = ^iRamData;

    assign oReadAddress = r_addr;
    assign oVGA_R       = r_rgb[2];
    assign oVGA_G       = r_rgb[1];
    assign oVGA_B       = r_rgb[0];
    assign oHSync       = r_hsync_n;
    assign oVSync       = r_vsync_n;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: a raster model predicts pins and address every clock.
// Expected border colour follows VGA_FRAME_BORDER_EN the same way the design does.
`timescale 1ns/1ps
module tb_vga_frame_reader;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 13;
    localparam int CELL_SHIFT = 3;
    localparam logic [4:0] BLANK = 5'b00011;
`ifdef VGA_FRAME_BORDER_EN
    localparam logic [2:0] EDGE_RGB = 3'b111;
`else
    localparam logic [2:0] EDGE_RGB = 3'b001;
`endif

    logic                  Clock = 1'b0;
    logic                  Reset = 1'b1;
    logic [ADDR_WIDTH-1:0] oReadAddress;
    logic [DATA_WIDTH-1:0] iRamData = '0;
    logic                  oVGA_R;
    logic                  oVGA_G;
    logic                  oVGA_B;
    logic                  oHSync;
    logic                  oVSync;
    logic                  oFrameStart;

    vga_frame_reader #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CELL_SHIFT (CELL_SHIFT)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oReadAddress (oReadAddress),
        .iRamData     (iRamData),
        .oVGA_R       (oVGA_R),
        .oVGA_G       (oVGA_G),
        .oVGA_B       (oVGA_B),
        .oHSync       (oHSync),
        .oVSync       (oVSync),
        .oFrameStart  (oFrameStart)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RAM contents: mode 0 is word[a] = a mod 8, mode 1 is all 3'b001.
    int ram_mode = 0;

    function automatic logic [2:0] ram_word(input int a);
        return (ram_mode == 0) ? 3'(a % 8) : 3'b001;
    endfunction

    // Registered-read RAM; upper data bits carry junk that the design must ignore.
    initial forever begin
        @(posedge Clock);
        iRamData <= {13'(int'(oReadAddress) * 5 + 3), ram_word(int'(oReadAddress))};
    end

    function automatic bit m_active(input int h, input int v);
        return (h < 640) && (v < 480);
    endfunction

    function automatic int m_addr(input int h, input int v);
        return (v / 8) * 80 + (h / 8);
    endfunction

    function automatic logic [4:0] m_pins(input int h, input int v);
        logic [2:0] rgb;
        rgb = 3'b000;
        if (m_active(h, v)) begin
            rgb = ram_word(m_addr(h, v));
`ifdef VGA_FRAME_BORDER_EN
            if (h == 0 || h == 639 || v == 0 || v == 479) rgb = 3'b111;
`endif
        end
        return {rgb, !(h >= 656 && h < 752), !(v >= 490 && v < 492)};
    endfunction

    // Reference raster position of the counter stage, advanced at every clock edge.
    int mh          = 0;
    int mv          = 0;
    bit rst_at_edge = 1'b0;

    initial forever begin
        @(posedge Clock);
        cyc++;
        rst_at_edge = Reset;
        if (Reset) begin
            mh = 0;
            mv = 0;
        end else if (mh == 799) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    end

    // Scoreboard: the entry pushed for the current raster position is due on the pins 3 clocks later.
    logic [4:0]            exp_q[$];
    logic [4:0]            exp_pins;
    logic [ADDR_WIDTH-1:0] exp_addr   = '0;
    bit                    prev_hs    = 1'b1;
    int                    last_fall  = -1;
    int                    n_hs_falls = 0;

    initial forever begin
        @(negedge Clock);
        if (cyc > 0) begin
            if (rst_at_edge) begin
                exp_q.delete();
                repeat (3) exp_q.push_back(BLANK);
                exp_addr  = '0;
                last_fall = -1;
            end
            exp_pins = (exp_q.size() > 0) ? exp_q.pop_front() : BLANK;
            check("pins", 32'({oVGA_R, oVGA_G, oVGA_B, oHSync, oVSync}), 32'(exp_pins));
            check("addr", 32'(oReadAddress), 32'(exp_addr));
            check("frame_start", 32'(oFrameStart), 32'(!Reset && mh == 0 && mv == 0));
            exp_q.push_back(m_pins(mh, mv));
            exp_addr = m_active(mh, mv) ? ADDR_WIDTH'(m_addr(mh, mv)) : '0;

            if (prev_hs && oHSync === 1'b0) begin
                n_hs_falls++;
                if (last_fall >= 0) check("hs_period", 32'(cyc - last_fall), 800);
                check("hs_align", 32'(mh), 659);
                last_fall = cyc;
            end
            if (!prev_hs && oHSync === 1'b1 && last_fall >= 0) begin
                check("hs_low", 32'(cyc - last_fall), 96);
            end
            prev_hs = (oHSync !== 1'b0);
        end
    end

    // Returns #1 after the edge that brings the counter stage to (h,v).
    task automatic wait_s1(input int h, input int v, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge Clock);
            #1;
            if (mh == h && mv == v) found = 1'b1;
        end
        check("wait_s1", 32'(found), 1);
    endtask

    task automatic pixel_at(input string tag, input int h, input int v, input logic [2:0] exp_rgb);
        wait_s1(h, v, 4000);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check(tag, 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(exp_rgb));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset    = 1'b1;
        ram_mode = 0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("rst_addr", 32'(oReadAddress), 0);
        check("rst_pins", 32'({oVGA_R, oVGA_G, oVGA_B, oHSync, oVSync}), 32'(BLANK));
        check("rst_fs", 32'(oFrameStart), 0);
        @(posedge Clock);
        #1 Reset = 1'b0;

        @(negedge Clock);
        check("rel_fs", 32'(oFrameStart), 1);
        @(negedge Clock);
        check("rel_fs_once", 32'(oFrameStart), 0);

        wait_s1(17, 9, 20000);
        @(posedge Clock);
        @(negedge Clock);
        check("addr_17_9", 32'(oReadAddress), 82);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rgb_17_9", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(3'b010));

        pixel_at("last_col", 639, 10, 3'b111);
        pixel_at("first_blank_col", 640, 11, 3'b000);

        wait_s1(300, 15, 20000);
        Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("mrst_fs", 32'(oFrameStart), 1);
        check("mrst_hs", 32'(oHSync), 1);
        check("mrst_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 0);
        repeat (12 * 800) @(posedge Clock);

        Reset    = 1'b1;
        ram_mode = 1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        pixel_at("border_top", 8, 0, EDGE_RGB);
        pixel_at("border_left", 0, 1, EDGE_RGB);
        pixel_at("inner", 320, 1, 3'b001);
        pixel_at("border_right", 639, 1, EDGE_RGB);
        pixel_at("blank_640", 640, 2, 3'b000);
        repeat (8 * 800) @(posedge Clock);

        check("hs_falls_seen", 32'(n_hs_falls >= 25), 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
